// File: rtl/pdm_mic_capture_if.sv
// iomem bus bundle between the SoC address decoder and pdm_mic_capture.
// Handshake: the master raises iomem_valid with addr/wstrb/wdata stable and holds it
// until it sees iomem_ready, a one-cycle pulse during which iomem_rdata is valid; the
// master then drops iomem_valid for at least one cycle before the next request.
interface pdm_mic_capture_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/pdm_mic_capture.sv
// PDM microphone receiver: bit-clock divider, boxcar ones-count decimator, sample FIFO on iomem.
// Optional PDM_CAPTURE_IRQ_EN builds a registered half-full/overflow interrupt; otherwise irq is 0.
module pdm_mic_capture #(
    parameter int CLK_DIV_HALF = 6,
    parameter int DEC_LOG2     = 5,
    parameter int FIFO_LOG2    = 3
) (
    input  logic             clk,
    input  logic             reset,
    pdm_mic_capture_if.slave bus,
    output logic             pdm_clk,
    input  logic             pdm_data,
    output logic             irq
);
    localparam int W     = DEC_LOG2 + 1;
    localparam int LW    = FIFO_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int DIV_W = (CLK_DIV_HALF > 1) ? $clog2(CLK_DIV_HALF) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV_HALF - 1);
    localparam logic [W-1:0]     HALF_WIN = W'(1 << (DEC_LOG2 - 1));
    localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);

    logic                ack_done;
    logic                fire;
    logic                is_write;
    logic                rd_pop;
    logic                ctrl_wr;
    logic                clear;
    logic [1:0]          reg_sel;
    logic                enable;
    logic                overflow;
    logic                sync1;
    logic                sync2;
    logic [DIV_W-1:0]    div_cnt;
    logic                cap;
    logic                win_last;
    logic [DEC_LOG2-1:0] bit_cnt;
    logic [W-1:0]        ones;
    logic [W-1:0]        win_total;
    logic                push_pend;
    logic [W-1:0]        push_sample;
    logic [W-1:0]        mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr;
    logic [FIFO_LOG2-1:0] rd_ptr;
    logic [LW-1:0]       level;
    logic                fifo_full;
    logic                fifo_empty;
    logic                do_push;
    logic [W-1:0]        head;
    logic [31:0]         status;
    logic [31:0]         rd_val;
    logic                unused_bits;

    assign unused_bits = &{1'b0, bus.iomem_addr[31:4], bus.iomem_addr[1:0], bus.iomem_wdata[31:2]};

    // A request is taken once per valid assertion; ack_done blocks re-acceptance until valid drops.
    assign reg_sel  = bus.iomem_addr[3:2];
    assign is_write = |bus.iomem_wstrb;
    assign fire     = bus.iomem_valid && !bus.iomem_ready && !ack_done;
    assign rd_pop   = fire && !is_write && (reg_sel == 2'd1) && !fifo_empty;
    assign ctrl_wr  = fire && (reg_sel == 2'd2) && bus.iomem_wstrb[0];
    assign clear    = ctrl_wr && bus.iomem_wdata[1];

    assign head = mem[rd_ptr];

    always_comb begin
        status              = '0;
        status[FIFO_LOG2:0] = level;
        status[8]           = overflow;
        status[9]           = enable;
        rd_val              = '0;
        case (reg_sel)
            2'd0:    rd_val = status;
            2'd1:    if (!fifo_empty) rd_val = {1'b1, 15'd0, {(16 - W){head[W-1]}}, head};
            2'd2:    rd_val = {31'd0, enable};
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.iomem_ready <= 1'b0;
            bus.iomem_rdata <= '0;
            ack_done        <= 1'b0;
        end else begin
            bus.iomem_ready <= fire;
            bus.iomem_rdata <= (fire && !is_write) ? rd_val : '0;
            if (fire)
                ack_done <= 1'b1;
            else if (!bus.iomem_valid)
                ack_done <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            enable <= 1'b0;
        else if (ctrl_wr)
            enable <= bus.iomem_wdata[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pdm_data;
            sync2 <= sync1;
        end
    end

    // The bit is captured on the same cycle the divider drives pdm_clk from 1 to 0.
    assign cap       = enable && (div_cnt == DIV_MAX) && pdm_clk;
    assign win_last  = &bit_cnt;
    assign win_total = ones + W'(sync2);

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            div_cnt <= '0;
            pdm_clk <= 1'b0;
            bit_cnt <= '0;
            ones    <= '0;
        end else begin
            if (div_cnt == DIV_MAX) begin
                div_cnt <= '0;
                pdm_clk <= !pdm_clk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (clear || (cap && win_last)) begin
                bit_cnt <= '0;
                ones    <= '0;
            end else if (cap) begin
                bit_cnt <= bit_cnt + 1'b1;
                ones    <= win_total;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            push_pend   <= 1'b0;
            push_sample <= '0;
        end else begin
            push_pend <= cap && win_last && !clear;
            if (cap && win_last)
                push_sample <= win_total - HALF_WIN;
        end
    end

    // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
    assign fifo_full  = (level == LVL_FULL);
    assign fifo_empty = (level == '0);
    assign do_push    = push_pend && !clear && (!fifo_full || rd_pop);

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_sample;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !rd_pop)
                level <= level + 1'b1;
            else if (rd_pop && !do_push)
                level <= level - 1'b1;
            if (push_pend && fifo_full && !rd_pop)
                overflow <= 1'b1;
        end
    end

`ifdef PDM_CAPTURE_IRQ_EN
    localparam logic [LW-1:0] LVL_HALF = LW'(DEPTH / 2);

    always_ff @(posedge clk) begin
        if (reset)
            irq <= 1'b0;
        else
            irq <= enable && ((level >= LVL_HALF) || overflow);
    end
`else
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_pdm_mic_capture.sv
// Directed bench for pdm_mic_capture: register access, bit clock, decimated values, FIFO edges.
module tb_pdm_mic_capture;
`ifdef PDM_CAPTURE_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pdm_clk;
    logic        pdm_data;
    logic        irq;
    int          n_tests = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int unsigned last_fire = 0;
    int unsigned f = 0;
    int          mode = 0;
    logic        data_val = 1'b1;
    logic        gen_bit = 1'b0;
    int          bit_idx = 0;
    int          hi_cnt = 0;
    logic [31:0] rd;
    logic [31:0] exp_q[$];

    pdm_mic_capture_if bus ();

    pdm_mic_capture dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .pdm_clk  (pdm_clk),
        .pdm_data (pdm_data),
        .irq      (irq)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: cycle %0d reached, required end before limit", cyc);
        $fatal(1, "watchdog");
    end

    // mode 0: constant data_val; 1: alternating; 2: window k holds 17+k ones (sample k+1)
    always @(posedge pdm_clk) begin
        if (mode == 1)
            gen_bit = bit_idx[0];
        else
            gen_bit = ((bit_idx % 32) < (17 + bit_idx / 32));
        bit_idx = bit_idx + 1;
    end
    assign pdm_data = (mode == 0) ? data_val : gen_bit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic bus_xfer(input logic [1:0] sel, input logic [3:0] strb,
                            input logic [31:0] wdata, output logic [31:0] rdata);
        logic seen;
        seen  = 1'b0;
        rdata = '0;
        @(negedge clk);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = {28'd0, sel, 2'b00};
        bus.iomem_wstrb = strb;
        bus.iomem_wdata = wdata;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.iomem_ready) begin
                seen      = 1'b1;
                rdata     = bus.iomem_rdata;
                last_fire = cyc;
                break;
            end
        end
        if (!seen)
            check("bus_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        check("ready_pulse", {31'd0, bus.iomem_ready}, 32'd0);
        @(negedge clk);
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'd0;
    endtask

    task automatic rd_reg(input logic [1:0] sel, output logic [31:0] rdata);
        bus_xfer(sel, 4'd0, 32'd0, rdata);
    endtask

    task automatic wr_reg(input logic [1:0] sel, input logic [31:0] wdata);
        logic [31:0] dummy;
        bus_xfer(sel, 4'hf, wdata, dummy);
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic measure_pdm_clk();
        int r1, f1, r2;
        logic prev;
        r1 = -1; f1 = -1; r2 = -1;
        prev = pdm_clk;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (!prev && pdm_clk) begin
                if (r1 < 0) r1 = i;
                else if (r2 < 0 && f1 >= 0) r2 = i;
            end
            if (prev && !pdm_clk && r1 >= 0 && f1 < 0) f1 = i;
            prev = pdm_clk;
        end
        check("pdm_clk_high", f1 - r1, 32'd6);
        check("pdm_clk_period", r2 - r1, 32'd12);
    endtask

    initial begin
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'd0;
        bus.iomem_addr  = 32'd0;
        bus.iomem_wdata = 32'd0;

        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, bus.iomem_ready}, 32'd0);
        check("rst_rdata", bus.iomem_rdata, 32'd0);
        check("rst_pdm_clk", {31'd0, pdm_clk}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;

        rd_reg(2'd0, rd);
        check("rst_status", rd, 32'd0);
        repeat (100) begin
            @(negedge clk);
            if (pdm_clk) hi_cnt++;
        end
        check("idle_pdm_clk", hi_cnt, 32'd0);
        rd_reg(2'd3, rd);
        check("reg3_read", rd, 32'd0);
        wr_reg(2'd3, 32'hffff_ffff);
        bus_xfer(2'd2, 4'b0010, 32'h1, rd);
        rd_reg(2'd0, rd);
        check("strb_ignored", rd, 32'd0);

        // all-ones stream
        data_val = 1'b1;
        wr_reg(2'd2, 32'h1);
        rd_reg(2'd2, rd);
        check("ctrl_readback", rd, 32'h1);
        measure_pdm_clk();
        wr_reg(2'd2, 32'h3);
        repeat (800) @(negedge clk);
        rd_reg(2'd1, rd);
        check("ones_0", rd, 32'h8000_0010);
        rd_reg(2'd1, rd);
        check("ones_1", rd, 32'h8000_0010);

        // all-zeros stream
        data_val = 1'b0;
        repeat (4) @(negedge clk);
        wr_reg(2'd2, 32'h3);
        repeat (800) @(negedge clk);
        rd_reg(2'd1, rd);
        check("zeros_0", rd, 32'h8000_fff0);
        rd_reg(2'd1, rd);
        check("zeros_1", rd, 32'h8000_fff0);

        // alternating stream
        mode = 1;
        repeat (4) @(negedge clk);
        wr_reg(2'd2, 32'h3);
        repeat (800) @(negedge clk);
        rd_reg(2'd1, rd);
        check("alt_0", rd, 32'h8000_0000);
        rd_reg(2'd1, rd);
        check("alt_1", rd, 32'h8000_0000);

        // nine windows with no reads: samples 1..9, the ninth overflows
        wr_reg(2'd2, 32'h2);
        mode    = 2;
        bit_idx = 0;
        wr_reg(2'd2, 32'h1);
        f = last_fire;
        wait_until(f + 9 * 384 + 192);
        wr_reg(2'd2, 32'h0);
        rd_reg(2'd0, rd);
        check("ovf_status", rd, 32'h108);
        check("ovf_irq_disabled", {31'd0, irq}, 32'd0);
        for (int k = 1; k <= 8; k++) exp_q.push_back(32'h8000_0000 | k);
        while (exp_q.size() > 0) begin
            rd_reg(2'd1, rd);
            check("drain_data", rd, exp_q.pop_front());
        end
        rd_reg(2'd1, rd);
        check("drain_empty", rd, 32'd0);
        wr_reg(2'd2, 32'h3);
        rd_reg(2'd0, rd);
        check("clear_status", rd, 32'h200);

        // disable mid-window must discard the partial count
        mode     = 0;
        data_val = 1'b0;
        repeat (4) @(negedge clk);
        wr_reg(2'd2, 32'h3);
        repeat (190) @(negedge clk);
        wr_reg(2'd2, 32'h0);
        data_val = 1'b1;
        repeat (4) @(negedge clk);
        wr_reg(2'd2, 32'h1);
        repeat (404) @(negedge clk);
        rd_reg(2'd1, rd);
        check("reenable_data", rd, 32'h8000_0010);
        rd_reg(2'd0, rd);
        check("reenable_status", rd, 32'h200);

        // interrupt threshold at half depth
        wr_reg(2'd2, 32'h2);
        wr_reg(2'd2, 32'h1);
        f = last_fire;
        wait_until(f + 1530);
        check("irq_level3", {31'd0, irq}, 32'd0);
        wait_until(f + 1540);
        check("irq_level4", {31'd0, irq}, {31'd0, IRQ_ON});
        rd_reg(2'd1, rd);
        check("irq_pop_data", rd, 32'h8000_0010);
        repeat (3) @(negedge clk);
        check("irq_after_pop", {31'd0, irq}, 32'd0);

        // pop coinciding with the ninth push into a full FIFO
        wr_reg(2'd2, 32'h2);
        wr_reg(2'd2, 32'h1);
        f = last_fire;
        wait_until(f + 3400);
        rd_reg(2'd0, rd);
        check("full_status", rd, 32'h208);
        while (cyc < f + 3457 - 2) @(negedge clk);
        rd_reg(2'd1, rd);
        check("collide_edge", last_fire, f + 3457);
        check("collide_data", rd, 32'h8000_0010);
        rd_reg(2'd0, rd);
        check("collide_status", rd, 32'h208);
        check("collide_irq", {31'd0, irq}, {31'd0, IRQ_ON});
        wait_until(f + 3841 + 5);
        rd_reg(2'd0, rd);
        check("full_drop_status", rd, 32'h308);

        // reset during a pending request drops it
        @(negedge clk);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = 32'h4;
        bus.iomem_wstrb = 4'd0;
        reset           = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_ready", {31'd0, bus.iomem_ready}, 32'd0);
        @(negedge clk);
        bus.iomem_valid = 1'b0;
        reset           = 1'b0;
        rd_reg(2'd0, rd);
        check("rst_mid_status", rd, 32'd0);

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
